// File: rtl/star_extent_finder.sv
// Star bounding-box search engine: walks right/left along the seed row, then down (and up when
// STAR_EXTENT_UPSCAN_EN is defined) along the midpoint column using one synchronous RAM read port.
module star_extent_finder #(
  parameter int X_W       = 6,
  parameter int Y_W       = 6,
  parameter int X_RES     = 60,
  parameter int Y_RES     = 60,
  parameter int ADDR_W    = 12,
  parameter int PIX_W     = 3,
  parameter int THRESHOLD = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [X_W-1:0]    left,
  output logic [X_W-1:0]    right,
  output logic [X_W-1:0]    mid_x,
  output logic [Y_W-1:0]    top,
  output logic [Y_W-1:0]    bottom,
  output logic [Y_W-1:0]    mid_y
);

  typedef enum logic [3:0] {
    IDLE, R_REQ, R_CHK, L_REQ, L_CHK, MID, D_REQ, D_CHK, U_REQ, U_CHK, DONE
  } state_t;

  localparam logic [X_W:0]   X_LIM = (X_W+1)'(X_RES);
  localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(Y_RES);
  localparam logic [X_W-1:0] X_MAX = X_W'(X_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(Y_RES - 1);
`ifdef STAR_EXTENT_UPSCAN_EN
  localparam state_t AFTER_D = U_REQ;
`else
  localparam state_t AFTER_D = DONE;
`endif

  state_t         state_q, state_d;
  logic [X_W-1:0] left_q, left_d, right_q, right_d, mid_x_q, mid_x_d;
  logic [Y_W-1:0] top_q, top_d, bottom_q, bottom_d, mid_y_q, mid_y_d;
  logic           err_q, err_d;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           bright;

  assign bright = rd_data > PIX_W'(THRESHOLD);

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    mid_x_d  = mid_x_q;
    top_d    = top_q;
    bottom_d = bottom_q;
    mid_y_d  = mid_y_q;
    err_d    = 1'b0;
    rd_en    = 1'b0;
    px       = '0;
    py       = '0;
    sum_x    = '0;
    sum_y    = '0;
    case (state_q)
      IDLE: begin
        // The err cycle counts as busy for the handshake: a start there is dropped.
        if (start && !err_q) begin
          if ({1'b0, x_in} >= X_LIM || {1'b0, y_in} >= Y_LIM) begin
            err_d = 1'b1;
          end else begin
            left_d   = x_in;
            right_d  = x_in;
            top_d    = y_in;
            bottom_d = y_in;
            state_d  = R_REQ;
          end
        end
      end
      R_REQ: begin
        if (right_q == X_MAX) state_d = L_REQ;
        else begin
          rd_en   = 1'b1;
          px      = right_q + X_W'(1);
          py      = top_q;
          state_d = R_CHK;
        end
      end
      R_CHK: begin
        if (bright) begin
          right_d = right_q + X_W'(1);
          state_d = R_REQ;
        end else state_d = L_REQ;
      end
      L_REQ: begin
        if (left_q == '0) state_d = MID;
        else begin
          rd_en   = 1'b1;
          px      = left_q - X_W'(1);
          py      = top_q;
          state_d = L_CHK;
        end
      end
      L_CHK: begin
        if (bright) begin
          left_d  = left_q - X_W'(1);
          state_d = L_REQ;
        end else state_d = MID;
      end
      MID: begin
        sum_x   = {1'b0, left_q} + {1'b0, right_q};
        mid_x_d = sum_x[X_W:1];
        state_d = D_REQ;
      end
      D_REQ: begin
        if (bottom_q == Y_MAX) state_d = AFTER_D;
        else begin
          rd_en   = 1'b1;
          px      = mid_x_q;
          py      = bottom_q + Y_W'(1);
          state_d = D_CHK;
        end
      end
      D_CHK: begin
        if (bright) begin
          bottom_d = bottom_q + Y_W'(1);
          state_d  = D_REQ;
        end else state_d = AFTER_D;
      end
`ifdef STAR_EXTENT_UPSCAN_EN
      U_REQ: begin
        if (top_q == '0) state_d = DONE;
        else begin
          rd_en   = 1'b1;
          px      = mid_x_q;
          py      = top_q - Y_W'(1);
          state_d = U_CHK;
        end
      end
      U_CHK: begin
        if (bright) begin
          top_d   = top_q - Y_W'(1);
          state_d = U_REQ;
        end else state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // mid_y is settled on entry to DONE so it is valid alongside the done pulse.
    if (state_d == DONE) begin
      sum_y   = {1'b0, top_d} + {1'b0, bottom_d};
      mid_y_d = sum_y[Y_W:1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      left_q   <= '0;
      right_q  <= '0;
      mid_x_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
      mid_y_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      mid_x_q  <= mid_x_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      mid_y_q  <= mid_y_d;
      err_q    <= err_d;
    end
  end

  assign rd_addr = rd_en ? (ADDR_W'(py) * ADDR_W'(X_RES) + ADDR_W'(px)) : '0;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign err     = err_q;
  assign left    = left_q;
  assign right   = right_q;
  assign mid_x   = mid_x_q;
  assign top     = top_q;
  assign bottom  = bottom_q;
  assign mid_y   = mid_y_q;

endmodule

// File: tb/tb_star_extent_finder.sv
// Directed bench for star_extent_finder; a small image model answers RAM reads one cycle later.
module tb_star_extent_finder;
`ifdef STAR_EXTENT_UPSCAN_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [5:0]  x_in = '0, y_in = '0;
  logic        rd_en, busy, done, err;
  logic [11:0] rd_addr;
  logic [2:0]  rd_data = '0;
  logic [5:0]  left, right, mid_x, top, bottom, mid_y;

  int checks = 0, failures = 0;
  int n_rd = 0, n_done = 0, n_a60 = 0;
  int scen = 0;

  star_extent_finder dut (
    .clk(clk), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .left(left), .right(right), .mid_x(mid_x),
    .top(top), .bottom(bottom), .mid_y(mid_y)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pix(input int x, input int y);
    int dx, dy;
    dx = (x > 30) ? x - 30 : 30 - x;
    dy = (y > 20) ? y - 20 : 20 - y;
    case (scen)
      0: return (x >= 20 && x <= 24 && y >= 30 && y <= 33) ? 3'd1 : 3'd0;
      1: return (x == 10 && y == 10) ? 3'd6 : 3'd0;
      2: return (x >= 57 && y <= 1) ? 3'd7 : 3'd0;
      3: return (dx + dy <= 5) ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    rd_data <= rd_en ? pix(int'(rd_addr) % 60, int'(rd_addr) / 60) : 3'd0;
    if (rd_en) n_rd <= n_rd + 1;
    if (rd_en && rd_addr == 12'd60) n_a60 <= n_a60 + 1;
    if (done) n_done <= n_done + 1;
  end

  // Returns the cycle offset (relative to start edge k) at which done was seen.
  task automatic run_search(input int x, input int y, output int cyc, output int rd, output int dn);
    int r0, d0;
    @(negedge clk);
    x_in = 6'(x); y_in = 6'(y); start = 1'b1;
    r0 = n_rd; d0 = n_done;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    rd = n_rd - r0; dn = n_done - d0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({rd_en, rd_addr, busy, done, err} !== '0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {rd_en, rd_addr, busy, done, err}); end
    checks++; if ({left, right, mid_x, top, bottom, mid_y} !== '0) begin failures++; $display("FAIL reset_res got=%h exp=0", {left, right, mid_x, top, bottom, mid_y}); end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_rect;
    int cyc, rd, dn;
    scen = 0;
    run_search(20, 30, cyc, rd, dn);
    checks++; if (cyc != (UP ? 24 : 22)) begin failures++; $display("FAIL rect_latency got=%0d exp=%0d", cyc, UP ? 24 : 22); end
    checks++; if (rd != (UP ? 11 : 10)) begin failures++; $display("FAIL rect_reads got=%0d exp=%0d", rd, UP ? 11 : 10); end
    checks++; if (dn != 1) begin failures++; $display("FAIL rect_done_cnt got=%0d exp=1", dn); end
    checks++; if (left !== 6'd20 || right !== 6'd24 || mid_x !== 6'd22) begin failures++; $display("FAIL rect_x got=%0d/%0d/%0d exp=20/24/22", left, right, mid_x); end
    checks++; if (top !== 6'd30 || bottom !== 6'd33 || mid_y !== 6'd31) begin failures++; $display("FAIL rect_y got=%0d/%0d/%0d exp=30/33/31", top, bottom, mid_y); end
  endtask

  task automatic test_single;
    int cyc, rd, dn;
    scen = 1;
    run_search(10, 10, cyc, rd, dn);
    checks++; if (cyc != (UP ? 10 : 8)) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", cyc, UP ? 10 : 8); end
    checks++; if (rd != (UP ? 4 : 3)) begin failures++; $display("FAIL single_reads got=%0d exp=%0d", rd, UP ? 4 : 3); end
    checks++; if ({left, right, mid_x, top, bottom, mid_y} !== {6{6'd10}}) begin failures++; $display("FAIL single_ext got=%0d %0d %0d %0d %0d %0d exp=all 10", left, right, mid_x, top, bottom, mid_y); end
  endtask

  task automatic test_corner;
    int cyc, rd, dn, a0;
    scen = 2; a0 = n_a60;
    run_search(57, 0, cyc, rd, dn);
    checks++; if (cyc != (UP ? 14 : 13)) begin failures++; $display("FAIL corner_latency got=%0d exp=%0d", cyc, UP ? 14 : 13); end
    checks++; if (rd != 5) begin failures++; $display("FAIL corner_reads got=%0d exp=5", rd); end
    checks++; if (n_a60 != a0) begin failures++; $display("FAIL corner_addr60 got=%0d exp=0", n_a60 - a0); end
    checks++; if (left !== 6'd57 || right !== 6'd59 || mid_x !== 6'd58) begin failures++; $display("FAIL corner_x got=%0d/%0d/%0d exp=57/59/58", left, right, mid_x); end
    checks++; if (top !== 6'd0 || bottom !== 6'd1 || mid_y !== 6'd0) begin failures++; $display("FAIL corner_y got=%0d/%0d/%0d exp=0/1/0", top, bottom, mid_y); end
  endtask

  task automatic test_diamond;
    int cyc, rd, dn;
    scen = 3;
    run_search(30, 20, cyc, rd, dn);
    checks++; if (cyc != (UP ? 50 : 38)) begin failures++; $display("FAIL diamond_latency got=%0d exp=%0d", cyc, UP ? 50 : 38); end
    checks++; if (left !== 6'd25 || right !== 6'd35 || mid_x !== 6'd30) begin failures++; $display("FAIL diamond_x got=%0d/%0d/%0d exp=25/35/30", left, right, mid_x); end
    checks++; if (top !== (UP ? 6'd15 : 6'd20) || bottom !== 6'd25) begin failures++; $display("FAIL diamond_tb got=%0d/%0d exp=%0d/25", top, bottom, UP ? 15 : 20); end
    checks++; if (mid_y !== (UP ? 6'd20 : 6'd22)) begin failures++; $display("FAIL diamond_mid_y got=%0d exp=%0d", mid_y, UP ? 20 : 22); end
  endtask

  task automatic test_err;
    int r0, d0;
    @(negedge clk);
    x_in = 6'd60; y_in = 6'd5; start = 1'b1;
    r0 = n_rd; d0 = n_done;
    @(posedge clk); #1; start = 1'b0;
    checks++; if ({err, done, busy, rd_en} !== 4'b1000) begin failures++; $display("FAIL err_pulse got=%b exp=1000", {err, done, busy, rd_en}); end
    @(posedge clk); #1;
    checks++; if ({err, busy} !== 2'b00) begin failures++; $display("FAIL err_clear got=%b exp=00", {err, busy}); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (n_rd != r0 || n_done != d0) begin failures++; $display("FAIL err_side got reads=%0d dones=%0d exp=0/0", n_rd - r0, n_done - d0); end
  endtask

  task automatic test_reset_mid;
    int d0, cyc, rd, dn;
    scen = 0;
    @(negedge clk);
    x_in = 6'd20; y_in = 6'd30; start = 1'b1;
    d0 = n_done;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rd_en, rd_addr, busy, done, err, left, right, mid_x, top, bottom, mid_y} !== '0) begin failures++; $display("FAIL midrst_outs got=%h exp=0", {rd_en, rd_addr, busy, done, err, left, right, mid_x, top, bottom, mid_y}); end
    @(negedge clk); resetn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (n_done != d0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", n_done - d0); end
    run_search(20, 30, cyc, rd, dn);
    checks++; if (cyc != (UP ? 24 : 22) || dn != 1) begin failures++; $display("FAIL rerun_timing got=%0d/%0d exp=%0d/1", cyc, dn, UP ? 24 : 22); end
    checks++; if (left !== 6'd20 || right !== 6'd24 || bottom !== 6'd33 || mid_y !== 6'd31) begin failures++; $display("FAIL rerun_ext got=%0d/%0d/%0d/%0d exp=20/24/33/31", left, right, bottom, mid_y); end
  endtask

  initial begin
    test_reset;
    test_rect;
    test_single;
    test_corner;
    test_diamond;
    test_err;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/star_extent_finder.md
# star_extent_finder

Parametrised star bounding-box engine for the star-finding pipeline. It takes a seed pixel from the raster star detector and searches the read-only image RAM to find the star's left, right, bottom and optionally top extents. It also produces the star's midpoint. It sits between the detector and the downstream star-mapping FSMs, and it owns one synchronous RAM read port.

## Interface
Parameters:
- X_W, 6, x coordinate width
- Y_W, 6, y coordinate width
- X_RES, 60, image width in pixels
- Y_RES, 60, image height in pixels
- ADDR_W, 12, RAM address width
- PIX_W, 3, pixel value width
- THRESHOLD, 0, a pixel is bright when its value > THRESHOLD and dark otherwise

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  pulse; seed is valid on this cycle
- x_in  in  X_W  seed x
- y_in  in  Y_W  seed y
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM address, equal to y*X_RES + x
- rd_data  in  PIX_W  RAM data, valid one cycle after rd_en/rd_addr
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse when results are valid
- err  out  1  one-cycle pulse, instead of done, on an out-of-range seed
- left, right, mid_x  out  X_W  horizontal extents and midpoint
- top, bottom, mid_y  out  Y_W  vertical extents and midpoint

## Operation
- States: IDLE, R_REQ, R_CHK, L_REQ, L_CHK, MID, D_REQ, D_CHK, U_REQ, U_CHK, DONE.
- IDLE, start high:
  - If x_in ≥ X_RES or y_in ≥ Y_RES, pulse err the next cycle, then return to IDLE.
  - Otherwise latch the seed: left = right = x_in and top = bottom = y_in. Go to R_REQ.
- The seed pixel is taken as bright and is never read.
- In IDLE, start is ignored when resetn is low. In every state other than IDLE, start is ignored.
- Right phase, along row y_seed:
  - R_REQ, right == X_RES-1: no read; go to L_REQ.
  - R_REQ otherwise: read (right+1, y_seed); go to R_CHK.
  - R_CHK, bright: right += 1; go to R_REQ.
  - R_CHK, dark: go to L_REQ.
- Left phase: mirror of the right phase. Probe (left-1, y_seed). The boundary is left == 0. Exit to MID.
- MID: mid_x = (left + right) >> 1. The sum is computed X_W+1 bits wide and then truncated. Go to D_REQ.
- Down phase, along column mid_x:
  - Probe (mid_x, bottom+1). The boundary is bottom == Y_RES-1.
  - Bright: bottom += 1.
  - Exit to U_REQ, or to DONE if STAR_EXTENT_UPSCAN_EN is undefined.
- Up phase: probe (mid_x, top-1). The boundary is top == 0. Bright: top -= 1. Exit to DONE.
- DONE:
  - done = 1.
  - mid_y = (top + bottom) >> 1, computed Y_W+1 bits wide.
  - Go to IDLE.
- Result outputs hold their values until the next accepted start.
- rd_addr is computed combinationally from the probe coordinate as (y<<5)+(y<<4)+... shift-add for 60, or generally y*X_RES + x. It is zero-extended to ADDR_W and driven only while rd_en is high; otherwise it is 0.

## Timing
- Reset: all outputs are 0 and the state is IDLE. This applies mid-search as well: the search is abandoned, no done pulse occurs, and no RAM read is issued in the cycle after reset.
- start is sampled at edge k. The first R_REQ occupies cycle k+1.
- Each probe takes 2 cycles (REQ, CHK). Each boundary skip takes 1 cycle. MID takes 1 cycle.
- Let P be the number of probes and S the number of skips. done is high in cycle k+2P+S+2.
- err is high in cycle k+1.
- A new start is accepted in the cycle after done or err.
- rd_data is sampled only in CHK states.

## Configuration
- STAR_EXTENT_UPSCAN_EN defined: the up phase is performed, and top may be less than y_seed.
- Undefined: U_REQ and U_CHK are unreachable, top = y_seed, and D_CHK and the down-phase skip go straight to DONE. This is the legacy behaviour, where the seed is the top-most pixel found by the raster scan.

## Test plan
- Rectangle x 20..24, y 30..33, seed (20,30), UPSCAN on. Required: left 20, right 24, mid_x 22, top 30, bottom 33, mid_y 31. P=11, S=0, so done at k+24 with exactly 11 rd_en pulses.
- Single pixel (10,10) with dark neighbours. Required: all extents 10. done at k+10 with UPSCAN on, k+8 with UPSCAN off.
- Star at x 57..59, y 0..1, seed (57,0). Required: right 59 with no read at x=60, mid_x 58, bottom 1, top 0 via skip. done at k+14.
- Diamond with seed (30,20) and column 30 bright over y 15..25, UPSCAN on. Required: top 15, bottom 25. With UPSCAN off: top 20.
- Seed (60,5). Required: err at k+1, no done pulse, no rd_en.
- Assert resetn low during D_CHK. Required: all outputs 0 the next cycle, IDLE, no done pulse. A following start re-runs the search correctly.
